// File: rtl/axis_fifo_drain.sv
// axis_fifo_drain: pulls a programmed number of beats from a FWFT FIFO and
// streams them out as an AXI4-Stream master, marking the final beat with TLAST.
// A two-entry output/skid buffer lets the FIFO read strobe depend only on
// registered state, never on m_axis_tready, while still sustaining one beat
// per cycle.
module axis_fifo_drain #(
    parameter int DATA_WIDTH = 256,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        xfer_beats,
    output logic                    busy,
    output logic                    done,
    input  logic [DATA_WIDTH-1:0]   fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nx;
    logic [LEN_W-1:0]        rd_left;
    logic [LEN_W-1:0]        out_left;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    skid_valid;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic                    pop;
    logic                    handshake;
    logic                    accept_start;

    // A pop needs the FIFO to have data, words still owed, and a guaranteed
    // free slot; requiring an empty skid register gives that slot without
    // looking at tready.
    assign pop          = (state == RUN) && !fifo_empty && (rd_left != '0) && !skid_valid;
    assign handshake    = out_valid && m_axis_tready;
    assign accept_start = (state == IDLE) && start;

    assign fifo_rd_en    = pop;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tkeep  = {(DATA_WIDTH/8){out_valid}};
    assign m_axis_tlast  = out_valid && (out_left == ONE);

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and status outputs; a zero-length start skips straight to DONE.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (xfer_beats != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (handshake && (out_left == ONE)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Beat counters: rd_left counts words still to pop, out_left counts beats still to send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_left  <= '0;
            out_left <= '0;
        end else if (accept_start) begin
            rd_left  <= xfer_beats;
            out_left <= xfer_beats;
        end else begin
            if (pop) begin
                rd_left <= rd_left - ONE;
            end
            if (handshake) begin
                out_left <= out_left - ONE;
            end
        end
    end

    // Output register plus skid register: popped words go to the output slot
    // when it is free or draining this cycle, otherwise they park in the skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (!out_valid || handshake) begin
                out_data  <= fifo_dout;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= fifo_dout;
                skid_valid <= 1'b1;
            end
        end else if (handshake) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_drain.sv
// Testbench for axis_fifo_drain: a behavioural FWFT FIFO feeds the DUT, a
// per-cycle monitor checks beat order, TLAST placement and AXIS hold rules,
// and a table of transfers plus a few hand-built sequences cover the corners.
module tb_axis_fifo_drain;

    localparam int DW = 256;
    localparam int LW = 8;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] xfer_beats;
    logic          busy;
    logic          done;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    logic [DW-1:0] mem [0:1023];
    logic [31:0]   wr_ptr = 32'd0;
    logic [31:0]   rd_ptr = 32'd0;

    int            errors = 0;
    int            checks = 0;
    int            exp_base = 0;
    int            exp_len = 0;
    int            beat_cnt = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            tog = 1'b0;

    typedef struct {
        int preload;
        int len;
        bit toggle;
        int exp_left;
        int exp_cycles;
    } vec_t;

    vec_t vecs [0:5];

    axis_fifo_drain #(
        .DATA_WIDTH(DW),
        .LEN_W     (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .xfer_beats   (xfer_beats),
        .busy         (busy),
        .done         (done),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr[9:0]];

    // FIFO read side: the head advances on every accepted pop.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            rd_ptr <= rd_ptr + 32'd1;
        end
    end

    // Every word carries its own FIFO index so order errors are visible.
    function automatic logic [DW-1:0] mk(input int k);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(k);
        return {8{w}};
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = mk(int'(wr_ptr));
            wr_ptr = wr_ptr + 32'd1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample and monitor at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (prev_stall) begin
            checkOutput("hold_valid", DW'(m_axis_tvalid), DW'(1'b1));
            checkOutput("hold_data", m_axis_tdata, prev_data);
            checkOutput("hold_last", DW'(m_axis_tlast), DW'(prev_last));
        end
        if (m_axis_tvalid) begin
            checkOutput("tkeep", DW'(m_axis_tkeep), DW'({KW{1'b1}}));
        end else begin
            checkOutput("idle_last", DW'(m_axis_tlast), DW'(1'b0));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (beat_cnt >= exp_len) begin
                checks++;
                errors++;
                $display("[TB] FAIL extra_beat: got beat %0d expected only %0d beats", beat_cnt + 1, exp_len);
            end else begin
                checkOutput("beat_data", m_axis_tdata, mk(exp_base + beat_cnt));
                checkOutput("beat_last", DW'(m_axis_tlast), DW'(beat_cnt == exp_len - 1));
            end
            beat_cnt++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int len);
        exp_len    = len;
        beat_cnt   = 0;
        start      = 1'b1;
        xfer_beats = len[LW-1:0];
        step();
        start      = 1'b0;
        checkOutput("busy_after_start", DW'(busy), DW'(1'b1));
    endtask

    // Wait for done, optionally toggling tready and probing that rd_en ignores it.
    task automatic wait_done(input int max, output int n);
        logic r0;
        n = 0;
        while (!done && n < max) begin
            if (tog) begin
                m_axis_tready = ~m_axis_tready;
                r0 = fifo_rd_en;
                m_axis_tready = ~m_axis_tready;
                #1;
                checkOutput("rd_en_vs_tready", DW'(fifo_rd_en), DW'(r0));
                m_axis_tready = ~m_axis_tready;
                #1;
            end
            step();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic wait_beats(input int target, input int max);
        int n;
        n = 0;
        while (beat_cnt < target && n < max) begin
            step();
            n++;
        end
        if (beat_cnt < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: got %0d beats expected %0d", beat_cnt, target);
        end
    endtask

    task automatic finish_xfer();
        checkOutput("beat_count", DW'(beat_cnt), DW'(exp_len));
        step();
        checkOutput("done_pulse", DW'(done), DW'(1'b0));
        checkOutput("busy_idle", DW'(busy), DW'(1'b0));
        exp_base += exp_len;
    endtask

    initial begin
        int n;

        vecs[0] = '{preload: 8,   len: 4,   toggle: 1'b0, exp_left: 4, exp_cycles: 5};
        vecs[1] = '{preload: 12,  len: 16,  toggle: 1'b1, exp_left: 0, exp_cycles: -1};
        vecs[2] = '{preload: 2,   len: 0,   toggle: 1'b0, exp_left: 2, exp_cycles: 0};
        vecs[3] = '{preload: 0,   len: 1,   toggle: 1'b0, exp_left: 1, exp_cycles: 2};
        vecs[4] = '{preload: 1,   len: 2,   toggle: 1'b0, exp_left: 0, exp_cycles: 3};
        vecs[5] = '{preload: 255, len: 255, toggle: 1'b0, exp_left: 0, exp_cycles: 256};

        rst           = 1'b1;
        start         = 1'b0;
        xfer_beats    = '0;
        m_axis_tready = 1'b0;
        step();
        checkOutput("rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        checkOutput("rst_rd_en", DW'(fifo_rd_en), DW'(1'b0));
        checkOutput("rst_busy", DW'(busy), DW'(1'b0));
        checkOutput("rst_done", DW'(done), DW'(1'b0));
        checkOutput("rst_tdata", m_axis_tdata, '0);
        rst = 1'b0;
        step();

        $display("[TB] table-driven transfers");
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = 1'b1;
            tog           = vecs[i].toggle;
            push(vecs[i].preload);
            applyStimulus(vecs[i].len);
            wait_done(600, n);
            if (vecs[i].exp_cycles >= 0) begin
                checkOutput("cycles_to_done", DW'(n), DW'(vecs[i].exp_cycles));
            end
            tog           = 1'b0;
            m_axis_tready = 1'b1;
            finish_xfer();
            checkOutput("fifo_left", DW'(wr_ptr - rd_ptr), DW'(vecs[i].exp_left));
        end

        $display("[TB] FIFO runs dry after the first beat");
        push(1);
        m_axis_tready = 1'b1;
        applyStimulus(3);
        wait_beats(1, 20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("gap_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
            step();
        end
        push(2);
        wait_done(20, n);
        finish_xfer();
        checkOutput("fifo_left_gap", DW'(wr_ptr - rd_ptr), DW'(0));

        $display("[TB] stalled sink and ignored restart");
        push(10);
        m_axis_tready = 1'b0;
        applyStimulus(4);
        step();
        step();
        checkOutput("stall_rd_en", DW'(fifo_rd_en), DW'(1'b0));
        checkOutput("stall_tvalid", DW'(m_axis_tvalid), DW'(1'b1));
        checkOutput("stall_popped", DW'(wr_ptr - rd_ptr), DW'(8));
        start      = 1'b1;
        xfer_beats = 8'd7;
        step();
        start = 1'b0;
        step();
        checkOutput("stall_rd_en2", DW'(fifo_rd_en), DW'(1'b0));
        m_axis_tready = 1'b1;
        wait_done(30, n);
        finish_xfer();
        checkOutput("fifo_left_restart", DW'(wr_ptr - rd_ptr), DW'(6));

        $display("[TB] reset mid-transfer");
        push(2);
        m_axis_tready = 1'b1;
        applyStimulus(8);
        wait_beats(1, 20);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        checkOutput("mid_rst_tlast", DW'(m_axis_tlast), DW'(1'b0));
        checkOutput("mid_rst_rd_en", DW'(fifo_rd_en), DW'(1'b0));
        checkOutput("mid_rst_busy", DW'(busy), DW'(1'b0));
        checkOutput("mid_rst_done", DW'(done), DW'(1'b0));
        checkOutput("mid_rst_tdata", m_axis_tdata, '0);
        prev_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_base += 2;
        checkOutput("fifo_left_rst", DW'(wr_ptr - rd_ptr), DW'(6));
        applyStimulus(6);
        wait_done(30, n);
        checkOutput("cycles_after_rst", DW'(n), DW'(7));
        finish_xfer();
        checkOutput("fifo_left_end", DW'(wr_ptr - rd_ptr), DW'(0));

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
